mem_arbiter: RTL and testbench

- Sits directly upstream of MainMemory and is its only master.
- Arbitrates line-sized transfers from the instruction-cache miss path (read only) and the data-cache miss/writeback path (read or write).
- Turns each granted request into a burst of WORDS_PER_LINE single-word accesses, paced by memValid.
- Assembles read lines and returns them with a one-cycle done pulse.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: the only master of MainMemory. Arbitrates line transfers
// between the I-cache fill path and the D-cache fill/writeback path using
// round-robin. Each grant becomes a burst of single-word accesses paced by
// memValid. Read lines are assembled in place and handed back with a
// one-cycle DONE pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | enables low; grant a pending request and latch its details
// BURST | one enable held high; offset advances on each memValid
// DONE  | enables low; one-cycle DONE pulse to the granted port
module mem_arbiter #(
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         I_REQ,
    input  logic [29:0]                  I_ADDR,
    output logic [32*WORDS_PER_LINE-1:0] I_LINE,
    output logic                         I_DONE,
    input  logic                         D_REQ,
    input  logic                         D_WE,
    input  logic [29:0]                  D_ADDR,
    input  logic [32*WORDS_PER_LINE-1:0] D_WLINE,
    output logic [32*WORDS_PER_LINE-1:0] D_RLINE,
    output logic                         D_DONE,
    output logic                         MEM_RE,
    output logic                         MEM_WE,
    output logic [29:0]                  MEM_ADDR,
    output logic [31:0]                  MEM_DATA_IN,
    input  logic [31:0]                  MEM_DOUT,
    input  logic                         memValid
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int LINE_W   = 32 * WORDS_PER_LINE;
    localparam logic [29:0] ALIGN_MASK = ~30'(WORDS_PER_LINE - 1);
    localparam logic [OFF_BITS-1:0] LAST_OFF = OFF_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_d_q, gnt_d_d;    // 1: D port owns the burst
    logic                  we_q, we_d;
    logic                  last_d_q, last_d_d;  // 1: D was served last
    logic [29:0]           base_q, base_d;
    logic [OFF_BITS-1:0]   off_q, off_d;
    logic [LINE_W-1:0]     wline_q, wline_d;
    logic [LINE_W-1:0]     i_line_q, i_line_d;
    logic [LINE_W-1:0]     d_line_q, d_line_d;
    logic                  pick_d;
    logic [OFF_BITS+4:0]   word_lsb;

    assign word_lsb = {off_q, 5'b0};
    assign I_LINE   = i_line_q;
    assign D_RLINE  = d_line_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            gnt_d_q  <= 1'b0;
            we_q     <= 1'b0;
            last_d_q <= 1'b0;
            base_q   <= '0;
            off_q    <= '0;
            wline_q  <= '0;
            i_line_q <= '0;
            d_line_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_d_q  <= gnt_d_d;
            we_q     <= we_d;
            last_d_q <= last_d_d;
            base_q   <= base_d;
            off_q    <= off_d;
            wline_q  <= wline_d;
            i_line_q <= i_line_d;
            d_line_q <= d_line_d;
        end
    end

    // Next-state, grant decision, burst sequencing and memory-side outputs.
    always_comb begin
        state_d     = state_q;
        gnt_d_d     = gnt_d_q;
        we_d        = we_q;
        last_d_d    = last_d_q;
        base_d      = base_q;
        off_d       = off_q;
        wline_d     = wline_q;
        i_line_d    = i_line_q;
        d_line_d    = d_line_q;
        pick_d      = 1'b0;
        MEM_RE      = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = '0;
        MEM_DATA_IN = '0;
        I_DONE      = 1'b0;
        D_DONE      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (I_REQ || D_REQ) begin
                    // With both pending, D wins only if I was served last.
                    pick_d  = D_REQ && (!I_REQ || !last_d_q);
                    gnt_d_d = pick_d;
                    we_d    = pick_d && D_WE;
                    base_d  = (pick_d ? D_ADDR : I_ADDR) & ALIGN_MASK;
                    wline_d = D_WLINE;
                    off_d   = '0;
                    state_d = S_BURST;
                end
            end

            S_BURST: begin
                MEM_RE   = !we_q;
                MEM_WE   = we_q;
                MEM_ADDR = base_q | 30'(off_q);
                if (we_q) begin
                    MEM_DATA_IN = wline_q[word_lsb +: 32];
                end
                if (memValid) begin
                    if (!we_q) begin
                        if (gnt_d_q) begin
                            d_line_d[word_lsb +: 32] = MEM_DOUT;
                        end else begin
                            i_line_d[word_lsb +: 32] = MEM_DOUT;
                        end
                    end
                    if (off_q == LAST_OFF) begin
                        state_d = S_DONE;
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                I_DONE   = !gnt_d_q;
                D_DONE   = gnt_d_q;
                last_d_d = gnt_d_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural MainMemory (16-cycle words), a
// reference memory image and expected line registers kept by the bench.
module tb_mem_arbiter;

    localparam int WPL       = 8;
    localparam int LW        = 32 * WPL;
    localparam int WORD_CYC  = 16;
    localparam int BURST_CYC = WPL * WORD_CYC;
    localparam int LATENCY   = BURST_CYC + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          I_REQ = 1'b0;
    logic [29:0]   I_ADDR = '0;
    logic [LW-1:0] I_LINE;
    logic          I_DONE;
    logic          D_REQ = 1'b0;
    logic          D_WE = 1'b0;
    logic [29:0]   D_ADDR = '0;
    logic [LW-1:0] D_WLINE = '0;
    logic [LW-1:0] D_RLINE;
    logic          D_DONE;
    logic          MEM_RE;
    logic          MEM_WE;
    logic [29:0]   MEM_ADDR;
    logic [31:0]   MEM_DATA_IN;
    logic [31:0]   MEM_DOUT;
    logic          memValid;

    mem_arbiter #(.WORDS_PER_LINE(WPL)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_LINE(I_LINE), .I_DONE(I_DONE),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WLINE(D_WLINE),
        .D_RLINE(D_RLINE), .D_DONE(D_DONE),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_IN(MEM_DATA_IN), .MEM_DOUT(MEM_DOUT), .memValid(memValid)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // MainMemory model: word completes after 16 enabled cycles; read data is
    // garbage except on memValid cycles; writes land on the falling edge.
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [3:0]  dcnt = '0;

    assign memValid = (MEM_RE || MEM_WE) && (dcnt == 4'hF);
    assign MEM_DOUT = memValid ? mem[MEM_ADDR[9:0]] : 32'hDEADBEEF;

    always @(posedge CLK) begin
        if (!(MEM_RE || MEM_WE)) dcnt <= '0;
        else                     dcnt <= dcnt + 4'd1;
    end

    always @(negedge CLK) begin
        if (MEM_WE && memValid) mem[MEM_ADDR[9:0]] = MEM_DATA_IN;
    end

    // Capture guard: lines may change only across an edge that saw memValid
    // or reset, and must never hold the off-cycle garbage word.
    logic          mon_on = 1'b0;
    logic          edge_mv = 1'b0;
    logic          edge_rst = 1'b1;
    logic [LW-1:0] prev_i = '0;
    logic [LW-1:0] prev_d = '0;
    int            spurious = 0;
    int            dead_seen = 0;

    always @(posedge CLK) begin
        edge_mv  = memValid;
        edge_rst = RST;
    end

    always @(negedge CLK) begin
        if (mon_on) begin
            if (!edge_rst && !edge_mv && (I_LINE !== prev_i || D_RLINE !== prev_d))
                spurious++;
            for (int k = 0; k < WPL; k++) begin
                if (I_LINE[32*k +: 32] === 32'hDEADBEEF) dead_seen++;
                if (D_RLINE[32*k +: 32] === 32'hDEADBEEF) dead_seen++;
            end
        end
        prev_i = I_LINE;
        prev_d = D_RLINE;
    end

    logic [LW-1:0] exp_i_line = '0;
    logic [LW-1:0] exp_d_line = '0;
    bit            last_served = 1'b0;   // 1: D was served last

    function automatic logic [LW-1:0] ref_line(input logic [29:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < WPL; k++) l[32*k +: 32] = ref_mem[base[9:0] + 10'(k)];
        return l;
    endfunction

    function automatic logic [29:0] rand_base();
        return {20'd0, 7'($urandom_range(0, 127)), 3'd0};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < WPL; k++) l[32*k +: 32] = $urandom() & 32'h7FFF_FFFF;
        return l;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; I_REQ = 1'b0; D_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        exp_i_line  = '0;
        exp_d_line  = '0;
        last_served = 1'b0;
    endtask

    // Drives one lone request through to completion and reports what was seen.
    task automatic run_txn(input bit is_d, input bit we, input logic [29:0] addr,
                           input logic [LW-1:0] wline, output int lat,
                           output int en_cyc, output int ndone_own,
                           output int ndone_other, output int seq_err);
        logic [29:0] base;
        int k;
        bit got;
        base = addr & ~30'(WPL - 1);
        lat = 0; en_cyc = 0; ndone_own = 0; ndone_other = 0; seq_err = 0;
        k = 0; got = 0;
        @(negedge CLK);
        if (is_d) begin
            D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_WLINE = wline;
        end else begin
            I_REQ = 1'b1; I_ADDR = addr;
        end
        while (!got && lat < 2000) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) begin
                I_ADDR  = rand_base();
                D_ADDR  = rand_base();
                D_WLINE = rand_line();
                if (is_d) D_WE = !we;
            end
            if (MEM_RE || MEM_WE) en_cyc++;
            if (memValid) begin
                if (MEM_ADDR !== 30'(base + 30'(k))) seq_err++;
                if (MEM_WE !== we || MEM_RE !== !we) seq_err++;
                if (we && MEM_DATA_IN !== wline[32*k +: 32]) seq_err++;
                if (!we && MEM_DATA_IN !== 32'd0) seq_err++;
                k++;
            end
            if (is_d ? D_DONE : I_DONE) begin
                got = 1; ndone_own++;
                I_REQ = 1'b0; D_REQ = 1'b0;
            end
            if (is_d ? I_DONE : D_DONE) ndone_other++;
        end
        if (k != WPL) seq_err++;
        repeat (2) begin
            @(negedge CLK);
            if (I_DONE || D_DONE) ndone_own++;
        end
        last_served = is_d;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({MEM_RE, MEM_WE} !== 2'b00) begin n_bad++;
            $display("FAIL reset_enables got %b want 00", {MEM_RE, MEM_WE}); end
        n_cmp++; if ({I_DONE, D_DONE} !== 2'b00) begin n_bad++;
            $display("FAIL reset_done got %b want 00", {I_DONE, D_DONE}); end
        n_cmp++; if (MEM_ADDR !== 30'd0 || MEM_DATA_IN !== 32'd0) begin n_bad++;
            $display("FAIL reset_mem_bus got %h/%h want 0/0", MEM_ADDR, MEM_DATA_IN); end
        n_cmp++; if (I_LINE !== '0 || D_RLINE !== '0) begin n_bad++;
            $display("FAIL reset_lines got %h / %h want 0", I_LINE, D_RLINE); end
        mon_on = 1'b1;
    endtask

    task automatic check_txn(input string nm, input int lat, input int en_cyc,
                             input int nown, input int noth, input int serr);
        n_cmp++; if (lat !== LATENCY) begin n_bad++;
            $display("FAIL %s_latency got %0d want %0d", nm, lat, LATENCY); end
        n_cmp++; if (en_cyc !== BURST_CYC) begin n_bad++;
            $display("FAIL %s_enable_cycles got %0d want %0d", nm, en_cyc, BURST_CYC); end
        n_cmp++; if (nown !== 1 || noth !== 0) begin n_bad++;
            $display("FAIL %s_done_pulses got own=%0d other=%0d want 1/0", nm, nown, noth); end
        n_cmp++; if (serr !== 0) begin n_bad++;
            $display("FAIL %s_bus_sequence got %0d errors want 0", nm, serr); end
    endtask

    task automatic test_i_fill();
        int lat, en, no, nt, se;
        for (int k = 0; k < WPL; k++) begin
            mem[10'h100 + 10'(k)]     = 32'hA0 + 32'(k);
            ref_mem[10'h100 + 10'(k)] = 32'hA0 + 32'(k);
        end
        run_txn(1'b0, 1'b0, 30'h100, '0, lat, en, no, nt, se);
        check_txn("i_fill", lat, en, no, nt, se);
        exp_i_line = ref_line(30'h100);
        n_cmp++; if (I_LINE !== exp_i_line) begin n_bad++;
            $display("FAIL i_fill_line got %h want %h", I_LINE, exp_i_line); end
    endtask

    task automatic test_d_write_read();
        int lat, en, no, nt, se;
        logic [LW-1:0] wl;
        for (int k = 0; k < WPL; k++) wl[32*k +: 32] = 32'h11 + 32'(k);
        run_txn(1'b1, 1'b1, 30'h205, wl, lat, en, no, nt, se);
        check_txn("d_write", lat, en, no, nt, se);
        for (int k = 0; k < WPL; k++) ref_mem[10'h200 + 10'(k)] = wl[32*k +: 32];
        n_cmp++; if (D_RLINE !== exp_d_line) begin n_bad++;
            $display("FAIL d_write_rline_kept got %h want %h", D_RLINE, exp_d_line); end
        run_txn(1'b1, 1'b0, 30'h200, '0, lat, en, no, nt, se);
        check_txn("d_read", lat, en, no, nt, se);
        exp_d_line = ref_line(30'h200);
        n_cmp++; if (D_RLINE !== exp_d_line) begin n_bad++;
            $display("FAIL d_read_line got %h want %h", D_RLINE, exp_d_line); end
    endtask

    task automatic test_random();
        int lat, en, no, nt, se;
        bit is_d, we;
        logic [29:0] a;
        logic [LW-1:0] wl;
        for (int t = 0; t < 6; t++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d && 1'($urandom_range(0, 1));
            a    = rand_base() | 30'($urandom_range(0, WPL - 1));
            wl   = rand_line();
            run_txn(is_d, we, a, wl, lat, en, no, nt, se);
            check_txn("random", lat, en, no, nt, se);
            if (we) begin
                for (int k = 0; k < WPL; k++) ref_mem[a[9:0] & 10'h3F8 | 10'(k)] = wl[32*k +: 32];
            end else if (is_d) begin
                exp_d_line = ref_line(a & ~30'(WPL - 1));
            end else begin
                exp_i_line = ref_line(a & ~30'(WPL - 1));
            end
            n_cmp++; if (I_LINE !== exp_i_line || D_RLINE !== exp_d_line) begin n_bad++;
                $display("FAIL random_lines t=%0d got %h / %h want %h / %h",
                         t, I_LINE, D_RLINE, exp_i_line, exp_d_line); end
        end
        for (int w = 0; w < 1024; w++) begin
            if (mem[w] !== ref_mem[w]) begin
                n_cmp++; n_bad++;
                $display("FAIL memory_image addr=%0h got %h want %h", w, mem[w], ref_mem[w]);
            end
        end
    endtask

    // Both ports request together; n_txn completions are observed. A port
    // is released on its DONE unless hold is set.
    task automatic run_both(input int n_txn, input bit hold, input logic [29:0] ia,
                            input logic [29:0] da, output int order[$],
                            output int gaps[$], output int cyc);
        int low_run;
        bit seen;
        order = {}; gaps = {};
        cyc = 0; low_run = 0; seen = 0;
        @(negedge CLK);
        I_REQ = 1'b1; I_ADDR = ia;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = da;
        while (order.size() < n_txn && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (MEM_RE || MEM_WE) begin
                if (seen && low_run > 0) gaps.push_back(low_run);
                seen = 1; low_run = 0;
            end else if (seen) begin
                low_run++;
            end
            if (D_DONE) begin order.push_back(1); if (!hold) D_REQ = 1'b0; end
            if (I_DONE) begin order.push_back(0); if (!hold) I_REQ = 1'b0; end
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_arbitration();
        int order[$], gaps[$], cyc;
        logic [29:0] ia, da;
        do_reset();
        ia = 30'h040; da = 30'h0C0;
        run_both(2, 1'b0, ia, da, order, gaps, cyc);
        exp_i_line = ref_line(ia);
        exp_d_line = ref_line(da);
        n_cmp++; if (order.size() != 2) begin n_bad++;
            $display("FAIL arb_completions got %0d want 2 (cycles %0d)", order.size(), cyc); end
        else begin
            n_cmp++; if (order[0] !== 1 || order[1] !== 0) begin n_bad++;
                $display("FAIL arb_order got %0d,%0d want 1,0 (1=D)", order[0], order[1]); end
        end
        n_cmp++; if (gaps.size() != 1 || gaps[0] !== 2) begin n_bad++;
            $display("FAIL arb_gap got n=%0d first=%0d want n=1 gap=2",
                     gaps.size(), gaps.size() > 0 ? gaps[0] : -1); end
        n_cmp++; if (I_LINE !== exp_i_line || D_RLINE !== exp_d_line) begin n_bad++;
            $display("FAIL arb_lines got %h / %h want %h / %h",
                     I_LINE, D_RLINE, exp_i_line, exp_d_line); end
        last_served = 1'b0;
    endtask

    task automatic test_back_to_back();
        int order[$], gaps[$], cyc;
        int first, errs, gap_errs;
        logic [29:0] ia, da;
        ia = rand_base(); da = rand_base();
        first = last_served ? 0 : 1;
        run_both(4, 1'b1, ia, da, order, gaps, cyc);
        errs = 0; gap_errs = 0;
        n_cmp++; if (order.size() != 4) begin n_bad++;
            $display("FAIL b2b_completions got %0d want 4 (cycles %0d)", order.size(), cyc); end
        else begin
            for (int j = 0; j < 4; j++) if (order[j] !== (first ^ (j % 2))) errs++;
            n_cmp++; if (errs != 0) begin n_bad++;
                $display("FAIL b2b_alternation got %0d%0d%0d%0d want first=%0d alternating",
                         order[0], order[1], order[2], order[3], first); end
            last_served = order[3] != 0;
        end
        for (int j = 0; j < gaps.size(); j++) if (gaps[j] !== 2) gap_errs++;
        n_cmp++; if (gaps.size() != 3 || gap_errs != 0) begin n_bad++;
            $display("FAIL b2b_gaps got n=%0d bad=%0d want n=3 all 2", gaps.size(), gap_errs); end
        exp_i_line = ref_line(ia);
        exp_d_line = ref_line(da);
        n_cmp++; if (I_LINE !== exp_i_line || D_RLINE !== exp_d_line) begin n_bad++;
            $display("FAIL b2b_lines got %h / %h want %h / %h",
                     I_LINE, D_RLINE, exp_i_line, exp_d_line); end
    endtask

    task automatic test_reset_mid_burst();
        int lat, en, no, nt, se, stray;
        logic [29:0] a;
        a = rand_base();
        @(negedge CLK);
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = a;
        repeat (40) @(negedge CLK);
        RST = 1'b1; D_REQ = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        exp_i_line = '0; exp_d_line = '0; last_served = 1'b0;
        n_cmp++; if ({MEM_RE, MEM_WE} !== 2'b00) begin n_bad++;
            $display("FAIL midrst_enables got %b want 00", {MEM_RE, MEM_WE}); end
        n_cmp++; if (D_RLINE !== '0 || I_LINE !== '0) begin n_bad++;
            $display("FAIL midrst_lines got %h / %h want 0", D_RLINE, I_LINE); end
        stray = 0;
        repeat (6) begin
            @(negedge CLK);
            if (D_DONE || I_DONE || MEM_RE || MEM_WE) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", stray); end
        run_txn(1'b0, 1'b0, a, '0, lat, en, no, nt, se);
        check_txn("post_rst_fill", lat, en, no, nt, se);
        exp_i_line = ref_line(a);
        n_cmp++; if (I_LINE !== exp_i_line) begin n_bad++;
            $display("FAIL post_rst_line got %h want %h", I_LINE, exp_i_line); end
    endtask

    task automatic test_capture_guard();
        n_cmp++; if (dead_seen != 0) begin n_bad++;
            $display("FAIL guard_garbage_word got %0d hits want 0", dead_seen); end
        n_cmp++; if (spurious != 0) begin n_bad++;
            $display("FAIL guard_line_change_off_valid got %0d want 0", spurious); end
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) begin
            mem[w]     = $urandom() & 32'h7FFF_FFFF;
            ref_mem[w] = mem[w];
        end
        test_reset();
        test_i_fill();
        test_d_write_read();
        test_random();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_burst();
        test_capture_guard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
